// File: rtl/jt10_adpcma_fetch_pkg.sv
// jt10_adpcma_pkg: shared types and constants for the ADPCM-A ROM fetch stage.
//   NumCh     - number of ADPCM-A channels in the slot rotation
//   RomAw     - ROM byte address width ({bank, addr})
//   fetch_st_e - ROM request FSM states
//   next_idx  - wrap-around increment of a channel index
package jt10_adpcma_pkg;

    localparam int unsigned NumCh = 6;
    localparam int unsigned RomAw = 24;

    typedef enum logic {
        StIdle,
        StWait
    } fetch_st_e;

    typedef logic [2:0] ch_idx_t;

    function automatic ch_idx_t next_idx(input ch_idx_t i);
        return (i == ch_idx_t'(NumCh - 1)) ? ch_idx_t'(0) : ch_idx_t'(i + ch_idx_t'(1));
    endfunction

endpackage

// File: rtl/jt10_adpcma_fetch_if.sv
// jt10_adpcma_fetch_if: ROM port of the ADPCM-A fetch stage.
//   rom_addr  24  byte address {bank, addr}, stable while rom_cs is high
//   rom_cs     1  request strobe
//   rom_data   8  returned byte
//   rom_ok     1  rom_data valid (only honoured while rom_cs is high)
// master: fetch stage side; slave: ROM side.
interface jt10_adpcma_fetch_if;
    import jt10_adpcma_pkg::*;

    logic [RomAw-1:0] rom_addr;
    logic             rom_cs;
    logic [7:0]       rom_data;
    logic             rom_ok;

    modport master (
        output rom_addr,
        output rom_cs,
        input  rom_data,
        input  rom_ok
    );

    modport slave (
        input  rom_addr,
        input  rom_cs,
        output rom_data,
        output rom_ok
    );

endinterface

// File: rtl/jt10_adpcma_rr_arb.sv
// jt10_adpcma_rr_arb: 6-way round-robin picker.
//   req    in   NumCh  pending requests
//   last   in   3      index of the last channel served
//   grant  out  3      first requesting channel after 'last' (wrapping)
//   valid  out  1      at least one request present
module jt10_adpcma_rr_arb
    import jt10_adpcma_pkg::*;
(
    input  logic [NumCh-1:0] req,
    input  ch_idx_t          last,
    output ch_idx_t          grant,
    output logic             valid
);

    ch_idx_t idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = last;
        for (int i = 0; i < NumCh; i++) begin
            idx = next_idx(idx);
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt10_adpcma_fetch.sv
// jt10_adpcma_fetch: ROM fetch stage between the ADPCM-A address counter and decoder.
// Each channel's read request is captured on its slot visit, fetched through a
// variable-latency ROM port, and the selected nibble is delivered on the channel's
// next visit of the 6-slot rotation.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cen             slot enable, one channel slot per cen
//   cur_ch    [5:0] one-hot current channel (non-one-hot slot is a no-op)
//   addr     [19:0] byte address, bank [3:0], sel (0 = [7:4], 1 = [3:0])
//   roe_n           read request (active low), decon: decoding this slot
//   clr             channel restart
//   rom             ROM port (jt10_adpcma_fetch_if.master)
//   nibble [3:0], nib_valid, clr_out   registered on each visit, held until next cen
//   late   [5:0]    sticky underrun flags, cleared per bit by clr_late [5:0]
//
// Build option: JT10_ADPCMA_FETCH_CACHE_EN enables a one-byte tag per channel so the
// second nibble of a byte is served without a ROM access.
module jt10_adpcma_fetch
    import jt10_adpcma_pkg::*;
(
    input  logic                 rst_n,
    input  logic                 clk,
    input  logic                 cen,
    input  logic [NumCh-1:0]     cur_ch,
    input  logic [19:0]          addr,
    input  logic [3:0]           bank,
    input  logic                 sel,
    input  logic                 roe_n,
    input  logic                 decon,
    input  logic                 clr,
    jt10_adpcma_fetch_if.master  rom,
    output logic [3:0]           nibble,
    output logic                 nib_valid,
    output logic                 clr_out,
    output logic [NumCh-1:0]     late,
    input  logic [NumCh-1:0]     clr_late
);

    // Per-channel entries
    logic [7:0]       data_q [NumCh];
    logic [RomAw-1:0] req_q  [NumCh];
    logic [NumCh-1:0] sel_q, clr_q, deliver_q, ready_q, pending_q;
`ifdef JT10_ADPCMA_FETCH_CACHE_EN
    logic [RomAw-1:0] tag_q  [NumCh];
    logic [NumCh-1:0] tag_v_q;
`endif

    // FSM state
    fetch_st_e        state_q;
    logic             rom_cs_q;
    logic [RomAw-1:0] rom_addr_q;
    ch_idx_t          cur_q;
    ch_idx_t          last_q;
    logic             abort_q;

    // Slot decode
    logic             one_hot;
    logic             vis;
    logic [NumCh-1:0] vis_oh;
    ch_idx_t          vis_idx;
    logic [RomAw-1:0] req_addr;
    logic             hit;
    logic             late_now;
    logic [NumCh-1:0] late_set;
    logic             abort_set;
    logic             fill;
    logic [NumCh-1:0] arb_req;
    ch_idx_t          arb_grant;
    logic             arb_valid;

    assign req_addr     = {bank, addr};
    assign rom.rom_cs   = rom_cs_q;
    assign rom.rom_addr = rom_addr_q;

    always_comb begin
        one_hot = (cur_ch != '0) && ((cur_ch & (cur_ch - NumCh'(1))) == '0);
        vis     = cen & one_hot;
        vis_oh  = vis ? cur_ch : '0;
        vis_idx = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (cur_ch[i]) vis_idx = ch_idx_t'(i);
        end
    end

`ifdef JT10_ADPCMA_FETCH_CACHE_EN
    // A restart invalidates the tag before the lookup, so clr always misses.
    assign hit = tag_v_q[vis_idx] & ~clr & (tag_q[vis_idx] == req_addr);
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        late_now  = vis & deliver_q[vis_idx] & ~ready_q[vis_idx];
        late_set  = late_now ? vis_oh : '0;
        // Any visit of the channel in flight that replaces, restarts or
        // underruns it makes the returning byte stale.
        abort_set = (state_q == StWait) && vis && (vis_idx == cur_q) &&
                    (~roe_n | clr | late_now);
        fill      = (state_q == StWait) & rom.rom_ok & ~abort_q & ~abort_set;
        // The channel being visited this clk may be re-latched; grant it next clk.
        arb_req   = pending_q & ~vis_oh;
    end

    jt10_adpcma_rr_arb u_arb (
        .req   (arb_req),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Entry update: ROM fill first, then the slot capture overrides for the same channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NumCh; c++) begin
                data_q[c] <= '0;
                req_q[c]  <= '0;
`ifdef JT10_ADPCMA_FETCH_CACHE_EN
                tag_q[c]  <= '0;
`endif
            end
            sel_q     <= '0;
            clr_q     <= '0;
            deliver_q <= '0;
            ready_q   <= '0;
            pending_q <= '0;
`ifdef JT10_ADPCMA_FETCH_CACHE_EN
            tag_v_q   <= '0;
`endif
        end else begin
            for (int c = 0; c < NumCh; c++) begin
                if (fill && (cur_q == ch_idx_t'(c))) begin
                    data_q[c]    <= rom.rom_data;
                    ready_q[c]   <= 1'b1;
                    pending_q[c] <= 1'b0;
`ifdef JT10_ADPCMA_FETCH_CACHE_EN
                    tag_q[c]     <= rom_addr_q;
                    tag_v_q[c]   <= 1'b1;
`endif
                end
                if (vis && (vis_idx == ch_idx_t'(c))) begin
                    if (late_now) pending_q[c] <= 1'b0;
                    deliver_q[c] <= decon & ~roe_n;
                    sel_q[c]     <= sel;
                    clr_q[c]     <= clr;
`ifdef JT10_ADPCMA_FETCH_CACHE_EN
                    if (clr) tag_v_q[c] <= 1'b0;
`endif
                    if (!roe_n) begin
                        if (hit) begin
                            ready_q[c]   <= 1'b1;
                            pending_q[c] <= 1'b0;
                        end else begin
                            ready_q[c]   <= 1'b0;
                            pending_q[c] <= 1'b1;
                            req_q[c]     <= req_addr;
                        end
                    end
                end
            end
        end
    end

    // ROM request FSM with registered strobe and address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            cur_q      <= '0;
            last_q     <= ch_idx_t'(NumCh - 1);
            abort_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        rom_addr_q <= req_q[arb_grant];
                        rom_cs_q   <= 1'b1;
                        cur_q      <= arb_grant;
                        last_q     <= arb_grant;
                        abort_q    <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (rom.rom_ok) begin
                        rom_cs_q <= 1'b0;
                        abort_q  <= 1'b0;
                        state_q  <= StIdle;
                    end else if (abort_set) begin
                        abort_q <= 1'b1;
                    end
                end
                default: begin
                    rom_cs_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    // Decoder-facing outputs, updated only on a valid slot visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble    <= '0;
            nib_valid <= 1'b0;
            clr_out   <= 1'b0;
            late      <= '0;
        end else begin
            if (vis) begin
                nib_valid <= deliver_q[vis_idx] & ready_q[vis_idx];
                nibble    <= (deliver_q[vis_idx] & ready_q[vis_idx]) ?
                             (sel_q[vis_idx] ? data_q[vis_idx][3:0] : data_q[vis_idx][7:4]) :
                             4'h0;
                clr_out   <= clr_q[vis_idx];
            end
            late <= ~clr_late & (late | late_set);
        end
    end

endmodule

// File: tb/tb_jt10_adpcma_fetch.sv
// Self-checking bench for jt10_adpcma_fetch: directed scenarios plus a randomized
// run checked against a rotation-level model (a visit's request shows up one
// rotation later as the nibble of the ROM byte at that address).
module tb_jt10_adpcma_fetch;
    import jt10_adpcma_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic [5:0]  cur_ch;
    logic [19:0] addr;
    logic [3:0]  bank;
    logic        sel, roe_n, decon, clr;
    logic [5:0]  clr_late;
    logic [3:0]  nibble;
    logic        nib_valid, clr_out;
    logic [5:0]  late;

    jt10_adpcma_fetch_if rom_bus ();

    jt10_adpcma_fetch dut (
        .rst_n     (rst_n),
        .clk       (clk),
        .cen       (cen),
        .cur_ch    (cur_ch),
        .addr      (addr),
        .bank      (bank),
        .sel       (sel),
        .roe_n     (roe_n),
        .decon     (decon),
        .clr       (clr),
        .rom       (rom_bus.master),
        .nibble    (nibble),
        .nib_valid (nib_valid),
        .clr_out   (clr_out),
        .late      (late),
        .clr_late  (clr_late)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          rom_delay = 3;
    bit          withhold = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    int          n_access = 0;
    logic [23:0] busy_addr;
    logic [23:0] issued[$];
    logic [3:0]  obs_nib;
    logic        obs_v, obs_clr;
    int          nxt_ch = 0;

    function automatic logic [7:0] romf(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC5;
    endfunction

    function automatic logic [3:0] nib_of(input logic [7:0] b, input logic s);
        return s ? b[3:0] : b[7:4];
    endfunction

    // ROM model: answers each request after rom_delay clocks unless withheld.
    initial begin
        rom_bus.rom_ok   = 1'b0;
        rom_bus.rom_data = 8'h00;
        forever begin
            @(negedge clk);
            rom_bus.rom_ok = 1'b0;
            if (busy) begin
                if (!withhold) begin
                    if (cnt > 1) begin
                        cnt--;
                    end else begin
                        rom_bus.rom_ok   = 1'b1;
                        rom_bus.rom_data = romf(busy_addr);
                        busy             = 1'b0;
                    end
                end
            end else if (rom_bus.rom_cs) begin
                busy      = 1'b1;
                cnt       = rom_delay;
                busy_addr = rom_bus.rom_addr;
                issued.push_back(rom_bus.rom_addr);
                n_access++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_idle();
        cen = 1'b0; cur_ch = '0; addr = '0; bank = '0;
        sel = 1'b0; roe_n = 1'b1; decon = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        clr_late = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nxt_ch = 0;
        @(negedge clk);
    endtask

    // One 8-clk slot visiting channel nxt_ch; outputs sampled right after the cen edge.
    task automatic step(input logic d, input logic r, input logic s, input logic c,
                        input logic [19:0] a, input logic [3:0] b);
        @(negedge clk);
        cur_ch = 6'b000001 << nxt_ch;
        decon = d; roe_n = ~r; sel = s; clr = c; addr = a; bank = b; cen = 1'b1;
        @(negedge clk);
        drive_idle();
        obs_nib = nibble; obs_v = nib_valid; obs_clr = clr_out;
        repeat (6) @(negedge clk);
        nxt_ch = (nxt_ch + 1) % 6;
    endtask

    task automatic noop_slot(input logic [5:0] code);
        @(negedge clk);
        cur_ch = code; decon = 1'b1; roe_n = 1'b0; clr = 1'b1; cen = 1'b1;
        addr = 20'h0F0F0; bank = 4'h9;
        @(negedge clk);
        drive_idle();
        obs_nib = nibble; obs_v = nib_valid; obs_clr = clr_out;
        repeat (6) @(negedge clk);
    endtask

    task automatic idle_to(input int ch);
        while (nxt_ch != ch) step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({nibble, nib_valid, clr_out, late} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 000", {nibble, nib_valid, clr_out, late});
        end
        checks++;
        if (rom_bus.rom_cs !== 1'b0 || rom_bus.rom_addr !== 24'h0) begin
            failures++;
            $display("FAIL reset_rom: cs=%b addr=%h required 0/000000",
                     rom_bus.rom_cs, rom_bus.rom_addr);
        end
        withhold = 1'b1;
        idle_to(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 20'h00055, 4'h3);
        checks++;
        if (rom_bus.rom_cs !== 1'b1 || rom_bus.rom_addr !== 24'h300055) begin
            failures++;
            $display("FAIL wait_before_reset: cs=%b addr=%h required 1/300055",
                     rom_bus.rom_cs, rom_bus.rom_addr);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rom_bus.rom_cs !== 1'b0 || rom_bus.rom_addr !== 24'h0) begin
            failures++;
            $display("FAIL reset_mid_wait: cs=%b addr=%h required 0/000000",
                     rom_bus.rom_cs, rom_bus.rom_addr);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nxt_ch = 0;
        @(negedge clk);
        withhold = 1'b0;          // stale rom_ok now lands on an idle FSM
        repeat (8) @(negedge clk);
        checks++;
        if (rom_bus.rom_cs !== 1'b0) begin
            failures++;
            $display("FAIL stale_ok_cs: cs=%b required 0", rom_bus.rom_cs);
        end
        idle_to(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
        checks++;
        if ({obs_v, obs_nib, obs_clr} !== 6'h00) begin
            failures++;
            $display("FAIL stale_ok_visit: got v=%b nib=%h clr=%b required 0/0/0",
                     obs_v, obs_nib, obs_clr);
        end
    endtask

    task automatic test_basic();
        int a0;
        do_reset();
        rom_delay = 3;
        idle_to(2);
        a0 = n_access;
        step(1'b1, 1'b1, 1'b0, 1'b0, 20'h00123, 4'h4);
        checks++;
        if (n_access - a0 != 1 || issued[$] !== 24'h400123) begin
            failures++;
            $display("FAIL basic_rom_addr: accesses=%0d addr=%h required 1/400123",
                     n_access - a0, issued[$]);
        end
    endtask

    task automatic test_cache();
        int a0;
        int want;
        idle_to(2);
        a0 = n_access;
        step(1'b1, 1'b1, 1'b1, 1'b0, 20'h00123, 4'h4);
        checks++;
        if (obs_v !== 1'b1 || obs_nib !== 4'hA) begin
            failures++;
            $display("FAIL basic_nibble: got v=%b nib=%h required 1/a", obs_v, obs_nib);
        end
`ifdef JT10_ADPCMA_FETCH_CACHE_EN
        want = 0;
`else
        want = 1;
`endif
        checks++;
        if (n_access - a0 != want) begin
            failures++;
            $display("FAIL cache_access: got %0d required %0d", n_access - a0, want);
        end
        idle_to(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
        checks++;
        if (obs_v !== 1'b1 || obs_nib !== 4'h7) begin
            failures++;
            $display("FAIL cache_nibble: got v=%b nib=%h required 1/7", obs_v, obs_nib);
        end
    endtask

    task automatic test_underrun();
        logic [23:0] ya;
        ya = 24'h201111;
        do_reset();
        rom_delay = 3;
        withhold = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 20'h0ABCD, 4'h1);
        idle_to(0);
        step(1'b1, 1'b1, 1'b0, 1'b0, ya[19:0], ya[23:20]);
        checks++;
        if (obs_v !== 1'b0 || late !== 6'b000001) begin
            failures++;
            $display("FAIL underrun_flag: got v=%b late=%b required 0/000001", obs_v, late);
        end
        withhold = 1'b0;
        idle_to(0);
        checks++;
        if (late !== 6'b000001) begin
            failures++;
            $display("FAIL late_sticky: got %b required 000001", late);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
        checks++;
        if (obs_v !== 1'b1 || obs_nib !== nib_of(romf(ya), 1'b0)) begin
            failures++;
            $display("FAIL underrun_discard: got v=%b nib=%h required 1/%h",
                     obs_v, obs_nib, nib_of(romf(ya), 1'b0));
        end
        @(negedge clk);
        clr_late = 6'b000001;
        @(negedge clk);
        clr_late = 6'b000000;
        checks++;
        if (late !== 6'b000000) begin
            failures++;
            $display("FAIL late_clear: got %b required 000000", late);
        end
    endtask

    task automatic test_arbitration();
        int i0;
        logic [23:0] ea;
        do_reset();
        rom_delay = 10;
        i0 = issued.size();
        for (int i = 0; i < 6; i++) begin
            ea = {4'(i + 1), 20'h00100 + 20'(i * 16)};
            step(1'b1, 1'b1, i[0], 1'b0, ea[19:0], ea[23:20]);
        end
        for (int i = 0; i < 6; i++) begin
            ea = {4'(i + 1), 20'h00100 + 20'(i * 16)};
            step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
            checks++;
            if (obs_v !== 1'b1 || obs_nib !== nib_of(romf(ea), i[0])) begin
                failures++;
                $display("FAIL arb_nibble ch%0d: got v=%b nib=%h required 1/%h",
                         i, obs_v, obs_nib, nib_of(romf(ea), i[0]));
            end
        end
        checks++;
        if (issued.size() - i0 != 6) begin
            failures++;
            $display("FAIL arb_count: got %0d required 6", issued.size() - i0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                ea = {4'(i + 1), 20'h00100 + 20'(i * 16)};
                checks++;
                if (issued[i0 + i] !== ea) begin
                    failures++;
                    $display("FAIL arb_order %0d: got %h required %h", i, issued[i0 + i], ea);
                end
            end
        end
        rom_delay = 3;
    endtask

    task automatic test_clear();
        int a0;
        logic [23:0] ca;
        ca = 24'h70ABC0;
        do_reset();
        rom_delay = 3;
        idle_to(5);
        step(1'b1, 1'b1, 1'b0, 1'b0, ca[19:0], ca[23:20]);
        idle_to(5);
        a0 = n_access;
        step(1'b1, 1'b1, 1'b1, 1'b1, ca[19:0], ca[23:20]);
        checks++;
        if (n_access - a0 != 1) begin
            failures++;
            $display("FAIL clear_miss: accesses=%0d required 1", n_access - a0);
        end
        idle_to(5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 4'h0);
        checks++;
        if (obs_clr !== 1'b1 || obs_v !== 1'b1 || obs_nib !== nib_of(romf(ca), 1'b1)) begin
            failures++;
            $display("FAIL clear_out: got clr=%b v=%b nib=%h required 1/1/%h",
                     obs_clr, obs_v, obs_nib, nib_of(romf(ca), 1'b1));
        end
    endtask

    task automatic test_random();
        logic [5:0]  exp_q [6];
        logic [5:0]  last_out;
        logic [5:0]  noops [4];
        logic [19:0] pool [4];
        logic        d, r, s, c;
        logic [19:0] a;
        logic [3:0]  b;
        int          ch;
        noops = '{6'b000000, 6'b000011, 6'b110000, 6'b111111};
        pool  = '{20'h00010, 20'h00011, 20'h3C5A0, 20'hFFFFF};
        do_reset();
        for (int i = 0; i < 6; i++) exp_q[i] = '0;
        last_out = '0;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                noop_slot(noops[$urandom_range(0, 3)]);
                checks++;
                if ({obs_v, obs_nib, obs_clr} !== last_out) begin
                    failures++;
                    $display("FAIL rand_noop %0d: got %h required %h",
                             n, {obs_v, obs_nib, obs_clr}, last_out);
                end
            end else begin
                ch = nxt_ch;
                d = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 4) != 0);
                s = 1'($urandom_range(0, 1));
                c = ($urandom_range(0, 7) == 0);
                a = pool[$urandom_range(0, 3)];
                b = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'hD;
                rom_delay = $urandom_range(1, 4);
                step(d, r, s, c, a, b);
                checks++;
                if ({obs_v, obs_nib, obs_clr} !== exp_q[ch]) begin
                    failures++;
                    $display("FAIL rand_visit %0d ch%0d: got %h required %h",
                             n, ch, {obs_v, obs_nib, obs_clr}, exp_q[ch]);
                end
                last_out  = exp_q[ch];
                exp_q[ch] = {d & r, (d & r) ? nib_of(romf({b, a}), s) : 4'h0, c};
            end
        end
        checks++;
        if (late !== 6'b000000) begin
            failures++;
            $display("FAIL rand_late: got %b required 000000", late);
        end
    endtask

    initial begin
        drive_idle();
        clr_late = '0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_cache();
        test_underrun();
        test_arbitration();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
